// File: rtl/valid_delay_pipe.sv
// valid_delay_pipe: WIDTH-bit, DEPTH-stage ready/valid pipeline register with
// bubble collapse, synchronous flush and a registered occupancy count.
module valid_delay_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  input  logic             FLUSH,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] v_r;
  logic [CW-1:0]    count_r;
  logic [DEPTH-1:0] rdy_s;
  logic [DEPTH-1:0] down_s;
  logic [DEPTH-1:0] load_s;
  logic [DEPTH-1:0] v_next_s;
  logic [WIDTH-1:0] din_s [DEPTH];

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(vec[i]);
    end
    return n;
  endfunction

  // Readiness ripples from the output: a stage accepts if it or anything after it has room
  always_comb begin
    logic acc;
    acc    = O_ready;
    rdy_s  = {DEPTH{1'b0}};
    down_s = {DEPTH{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      down_s[k] = acc;
      acc       = acc || !v_r[k];
      rdy_s[k]  = acc;
    end
  end

  assign I_ready = rdy_s[0] && !FLUSH;

  // Transfer network: each stage receives what the previous stage sends this cycle
  always_comb begin
    logic             carry;
    logic             send;
    logic [WIDTH-1:0] prev_d;
    carry    = I_valid && I_ready;
    send     = 1'b0;
    prev_d   = I;
    load_s   = {DEPTH{1'b0}};
    v_next_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      send        = v_r[k] && down_s[k];
      load_s[k]   = carry;
      din_s[k]    = prev_d;
      v_next_s[k] = carry || (v_r[k] && !send);
      carry       = send;
      prev_d      = data_r[k];
    end
  end

  // State update: reset clears everything, flush clears valids but keeps data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_r     <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
    end else if (FLUSH) begin
      v_r     <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      v_r     <= v_next_s;
      count_r <= popcount(v_next_s);
      for (int k = 0; k < DEPTH; k++) begin
        if (load_s[k]) begin
          data_r[k] <= din_s[k];
        end
      end
    end
  end

  assign O       = data_r[DEPTH-1];
  assign O_valid = v_r[DEPTH-1] && !FLUSH;
  assign count   = count_r;

  valid_delay_pipe_checker #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_checker (
    .CLK    (CLK),
    .RESET  (RESET),
    .FLUSH  (FLUSH),
    .I_valid(I_valid),
    .I_ready(I_ready),
    .O_valid(O_valid),
    .O_ready(O_ready),
    .O      (O),
    .count  (count)
  );

endmodule

// Temporal properties of the pipe; simulation-only, no logic.
module valid_delay_pipe_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic             CLK,
  input logic             RESET,
  input logic             FLUSH,
  input logic             I_valid,
  input logic             I_ready,
  input logic             O_valid,
  input logic             O_ready,
  input logic [WIDTH-1:0] O,
  input logic [CW-1:0]    count
);

  a_hold_stalled: assert property (@(posedge CLK) disable iff (RESET || FLUSH)
    O_valid && !O_ready |=> O_valid && $stable(O));

  a_count_range: assert property (@(posedge CLK) disable iff (RESET)
    count <= CW'(DEPTH));

  a_latency: assert property (@(posedge CLK) disable iff (RESET || FLUSH)
    I_valid && I_ready |-> ##DEPTH O_valid);

endmodule

// File: tb/tb_valid_delay_pipe.sv
// Directed self-checking bench for valid_delay_pipe (DEPTH=4 and DEPTH=1 instances).
module tb_valid_delay_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] i4, o4, i1, o1;
  logic       iv4, ir4, ov4, or4, fl4;
  logic       iv1, ir1, ov1, or1, fl1;
  logic [2:0] cnt4;
  logic [0:0] cnt1;
  int tests = 0;
  int fails = 0;

  valid_delay_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .I(i4), .I_valid(iv4), .I_ready(ir4),
    .O(o4), .O_valid(ov4), .O_ready(or4), .FLUSH(fl4), .count(cnt4)
  );

  valid_delay_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .CLK(clk), .RESET(rst), .I(i1), .I_valid(iv1), .I_ready(ir1),
    .O(o1), .O_valid(ov1), .O_ready(or1), .FLUSH(fl1), .count(cnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; iv4 = 1'b1; i4 = 8'hFF; or4 = 1'b0; fl4 = 1'b0;
    iv1 = 1'b1; i1 = 8'hFF; or1 = 1'b0; fl1 = 1'b0;
    tick; tick;
    tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_ovalid: got %b expected 0", ov4); end
    tests++; if (cnt4 !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", cnt4); end
    tests++; if (o4 !== 8'h00) begin fails++; $display("FAIL reset_o: got %h expected 00", o4); end
    tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL reset_iready: got %b expected 1", ir4); end
    tests++; if (cnt1 !== 1'd0) begin fails++; $display("FAIL reset_count_d1: got %0d expected 0", cnt1); end
    rst = 1'b0; iv4 = 1'b0; iv1 = 1'b0;
    tick;
    tests++; if (cnt4 !== 3'd0) begin fails++; $display("FAIL reset_nothing_accepted: got %0d expected 0", cnt4); end
  endtask

  task automatic test_stream;
    logic exp_v;
    or4 = 1'b1;
    for (int e = 0; e < 12; e++) begin
      iv4 = (e < 8); i4 = 8'(e + 1);
      settle;
      if (e < 8) begin
        tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL stream_iready[%0d]: got %b expected 1", e, ir4); end
      end
      tick;
      exp_v = (e >= 3 && e <= 10);
      tests++; if (ov4 !== exp_v) begin fails++; $display("FAIL stream_ovalid[%0d]: got %b expected %b", e, ov4, exp_v); end
      if (exp_v) begin
        tests++; if (o4 !== 8'(e - 2)) begin fails++; $display("FAIL stream_o[%0d]: got %h expected %h", e, o4, 8'(e - 2)); end
      end
      if (e >= 3 && e <= 7) begin
        tests++; if (cnt4 !== 3'd4) begin fails++; $display("FAIL stream_count[%0d]: got %0d expected 4", e, cnt4); end
      end
    end
    iv4 = 1'b0;
  endtask

  task automatic test_fill_stall;
    int n;
    n = 0;
    or4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      iv4 = 1'b1; i4 = 8'(8'hA0 + n);
      settle;
      tests++; if (ir4 !== (c < 4)) begin fails++; $display("FAIL fill_iready[%0d]: got %b expected %b", c, ir4, (c < 4)); end
      tick;
      if (c < 4) n++;
    end
    tests++; if (cnt4 !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", cnt4); end
    tests++; if (o4 !== 8'hA0 || ov4 !== 1'b1) begin fails++; $display("FAIL fill_head: got %h/%b expected a0/1", o4, ov4); end
    or4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      iv4 = (n < 6); i4 = 8'(8'hA0 + n);
      settle;
      tests++; if (ov4 !== 1'b1 || o4 !== 8'(8'hA0 + c)) begin fails++; $display("FAIL drain_o[%0d]: got %h/%b expected %h/1", c, o4, ov4, 8'(8'hA0 + c)); end
      if (c < 2) begin
        tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL overlap_iready[%0d]: got %b expected 1", c, ir4); end
      end
      tick;
      if (iv4) n++;
      if (c < 2) begin
        tests++; if (cnt4 !== 3'd4) begin fails++; $display("FAIL overlap_count[%0d]: got %0d expected 4", c, cnt4); end
      end
    end
    iv4 = 1'b0;
    tests++; if (ov4 !== 1'b0 || cnt4 !== 3'd0) begin fails++; $display("FAIL drain_empty: got %b/%0d expected 0/0", ov4, cnt4); end
  endtask

  task automatic test_bubble;
    or4 = 1'b0; iv4 = 1'b1; i4 = 8'h11;
    tick;
    iv4 = 1'b0;
    tick; tick; tick;
    iv4 = 1'b1; i4 = 8'h22;
    tick;
    iv4 = 1'b0;
    tick; tick; tick;
    tests++; if (cnt4 !== 3'd2) begin fails++; $display("FAIL bubble_count: got %0d expected 2", cnt4); end
    tests++; if (ov4 !== 1'b1 || o4 !== 8'h11) begin fails++; $display("FAIL bubble_head: got %h/%b expected 11/1", o4, ov4); end
    or4 = 1'b1;
    tick;
    tests++; if (ov4 !== 1'b1 || o4 !== 8'h22) begin fails++; $display("FAIL bubble_second: got %h/%b expected 22/1", o4, ov4); end
    tests++; if (cnt4 !== 3'd1) begin fails++; $display("FAIL bubble_count1: got %0d expected 1", cnt4); end
    tick;
    tests++; if (ov4 !== 1'b0 || cnt4 !== 3'd0) begin fails++; $display("FAIL bubble_empty: got %b/%0d expected 0/0", ov4, cnt4); end
  endtask

  task automatic test_flush;
    or4 = 1'b0; iv4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i4 = 8'(8'hB1 + k);
      tick;
    end
    iv4 = 1'b0;
    tick;
    tests++; if (cnt4 !== 3'd3 || ov4 !== 1'b1) begin fails++; $display("FAIL preflush: got %0d/%b expected 3/1", cnt4, ov4); end
    fl4 = 1'b1; iv4 = 1'b1; i4 = 8'h55;
    settle;
    tests++; if (ir4 !== 1'b0) begin fails++; $display("FAIL flush_iready: got %b expected 0", ir4); end
    tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL flush_ovalid: got %b expected 0", ov4); end
    tick;
    tests++; if (cnt4 !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", cnt4); end
    fl4 = 1'b0;
    settle;
    tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL postflush_ovalid: got %b expected 0", ov4); end
    tests++; if (o4 !== 8'hB1) begin fails++; $display("FAIL flush_data_kept: got %h expected b1", o4); end
    tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL postflush_iready: got %b expected 1", ir4); end
    tick;
    iv4 = 1'b0;
    tests++; if (cnt4 !== 3'd1) begin fails++; $display("FAIL postflush_accept: got %0d expected 1", cnt4); end
    or4 = 1'b1;
    tick; tick; tick;
    tests++; if (ov4 !== 1'b1 || o4 !== 8'h55) begin fails++; $display("FAIL postflush_out: got %h/%b expected 55/1", o4, ov4); end
    tick;
    tests++; if (cnt4 !== 3'd0) begin fails++; $display("FAIL postflush_drain: got %0d expected 0", cnt4); end
  endtask

  task automatic test_mid_reset;
    or4 = 1'b0; iv4 = 1'b1; i4 = 8'hC1;
    tick;
    i4 = 8'hC2;
    tick;
    iv4 = 1'b0;
    tests++; if (cnt4 !== 3'd2) begin fails++; $display("FAIL midreset_pre: got %0d expected 2", cnt4); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (cnt4 !== 3'd0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", cnt4); end
    tests++; if (o4 !== 8'h00 || ov4 !== 1'b0) begin fails++; $display("FAIL midreset_o: got %h/%b expected 00/0", o4, ov4); end
    settle;
    tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL midreset_iready: got %b expected 1", ir4); end
  endtask

  task automatic test_depth1;
    or1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv1 = (k < 3); i1 = 8'(8'h3C + k);
      settle;
      if (k < 3) begin
        tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL d1_iready[%0d]: got %b expected 1", k, ir1); end
      end
      tick;
      if (k < 3) begin
        tests++; if (ov1 !== 1'b1 || o1 !== 8'(8'h3C + k) || cnt1 !== 1'd1) begin fails++; $display("FAIL d1_out[%0d]: got %h/%b/%0d expected %h/1/1", k, o1, ov1, cnt1, 8'(8'h3C + k)); end
      end else begin
        tests++; if (ov1 !== 1'b0 || cnt1 !== 1'd0) begin fails++; $display("FAIL d1_empty: got %b/%0d expected 0/0", ov1, cnt1); end
      end
    end
    or1 = 1'b0; iv1 = 1'b1; i1 = 8'h40;
    tick;
    iv1 = 1'b0;
    settle;
    tests++; if (ir1 !== 1'b0 || ov1 !== 1'b1 || o1 !== 8'h40) begin fails++; $display("FAIL d1_full: got ir=%b ov=%b o=%h expected 0/1/40", ir1, ov1, o1); end
    or1 = 1'b1;
    settle;
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL d1_full_pop_iready: got %b expected 1", ir1); end
    tick;
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL d1_drain: got %b expected 0", ov1); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_fill_stall;
    test_bubble;
    test_flush;
    test_mid_reset;
    test_depth1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
